// File: rtl/excp_commit.sv
// Writeback exception/ERTN commit controller: prioritizes exception flags, pulses CSR commit
// inputs, flushes younger stages and holds a pre-IF redirect until it is accepted. Optional EXCP_STAT_EN.
module excp_commit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_valid,
  input  logic [31:0] ws_pc,
  input  logic [5:0]  ws_excp,
  input  logic        ws_ertn,
  output logic        ws_allowin,
  input  logic [31:0] ex_entry,
  input  logic [31:0] era_value,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic        ertn_flush,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
`ifdef EXCP_STAT_EN
  output logic [31:0] excp_cnt,
  output logic [31:0] ertn_cnt,
`endif
  input  logic        redirect_ready
);

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  typedef enum logic {IDLE = 1'b0, REDIR = 1'b1} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_redirect_pc;
  logic        w_commit;
  logic        w_exc;
  logic        w_ertn;

  // Flag order INT > ADEF > INE > SYS > BRK > ALE
  function automatic logic [5:0] f_ecode(input logic [5:0] excp);
    logic [5:0] code;
    code = 6'h00;
    if (excp[0])      code = ECODE_INT;
    else if (excp[1]) code = ECODE_ADEF;
    else if (excp[2]) code = ECODE_INE;
    else if (excp[3]) code = ECODE_SYS;
    else if (excp[4]) code = ECODE_BRK;
    else if (excp[5]) code = ECODE_ALE;
    else              code = 6'h00;
    return code;
  endfunction

  // Commit decode and combinational CSR-side pulses; an exception suppresses a coincident ERTN
  always_comb begin
    w_commit    = resetn & (r_state == IDLE) & ws_valid;
    w_exc       = w_commit & (|ws_excp);
    w_ertn      = w_commit & ws_ertn & ~(|ws_excp);
    wb_ex       = w_exc;
    wb_ecode    = 6'h00;
    wb_pc       = 32'h0000_0000;
    wb_esubcode = 9'h000;
    ertn_flush  = w_ertn;
    flush       = w_exc | w_ertn;
    if (w_exc) begin
      wb_ecode = f_ecode(ws_excp);
      wb_pc    = ws_pc;
    end else begin
      wb_ecode = 6'h00;
      wb_pc    = 32'h0000_0000;
    end
  end

  // Next-state logic and state-derived outputs
  always_comb begin
    w_next_state   = r_state;
    ws_allowin     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = r_redirect_pc;
    case (r_state)
      IDLE: begin
        ws_allowin = 1'b1;
        if (w_exc || w_ertn) w_next_state = REDIR;
        else                 w_next_state = IDLE;
      end
      REDIR: begin
        redirect_valid = 1'b1;
        if (redirect_ready) w_next_state = IDLE;
        else                w_next_state = REDIR;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State and redirect target; the target only loads on a commit, so it is stable while pending
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_redirect_pc <= 32'h0000_0000;
    end else begin
      r_state <= w_next_state;
      if (w_exc)       r_redirect_pc <= ex_entry;
      else if (w_ertn) r_redirect_pc <= era_value;
      else             r_redirect_pc <= r_redirect_pc;
    end
  end

`ifdef EXCP_STAT_EN
  logic [31:0] r_excp_cnt;
  logic [31:0] r_ertn_cnt;

  // Committed-event counters, wrapping naturally
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_excp_cnt <= 32'h0000_0000;
      r_ertn_cnt <= 32'h0000_0000;
    end else begin
      if (w_exc)  r_excp_cnt <= r_excp_cnt + 32'd1;
      if (w_ertn) r_ertn_cnt <= r_ertn_cnt + 32'd1;
    end
  end

  assign excp_cnt = r_excp_cnt;
  assign ertn_cnt = r_ertn_cnt;
`endif

endmodule

// File: doc/excp_commit.md
# excp_commit

Writeback-stage exception and ERTN commit controller for the LoongArch pipeline. It prioritizes the exception flags carried by the retiring instruction and drives the CSR unit's commit-side inputs (exception, ecode/esubcode, PC, ERTN flush). It kills younger stages and issues a redirect to pre-IF through a valid/ready handshake, using the exception entry or ERA as the target. New commits are blocked until the redirect is accepted.

## Interface
- No parameters; ecodes are fixed: INT=0x00, ADEF=0x08, ALE=0x09, SYS=0x0B, BRK=0x0C, INE=0x0D.
- `clk` input 1: the only clock.
- `resetn` input 1: synchronous, active-low reset.
- `ws_valid` input 1: WB holds a valid instruction.
- `ws_pc` input 32: PC of the WB instruction.
- `ws_excp` input 6: exception flags. Bit 0 INT (sampled has_int), 1 ADEF, 2 INE, 3 SYS, 4 BRK, 5 ALE.
- `ws_ertn` input 1: the WB instruction is ERTN.
- `ws_allowin` output 1: WB may accept or retire an instruction.
- `ex_entry` input 32: EENTRY value from the CSR unit.
- `era_value` input 32: ERA value from the CSR unit.
- `wb_ex` output 1: exception commit pulse to the CSR unit.
- `wb_ecode` output 6: ecode to the CSR unit.
- `wb_esubcode` output 9: esubcode to the CSR unit; always 0.
- `wb_pc` output 32: faulting PC to the CSR unit.
- `ertn_flush` output 1: ERTN commit pulse to the CSR unit.
- `flush` output 1: kills all younger pipeline stages.
- `redirect_valid` output 1: pre-IF redirect request.
- `redirect_pc` output 32: redirect target.
- `redirect_ready` input 1: pre-IF accepts the redirect.
- `excp_cnt` output 32: number of exceptions committed (EXCP_STAT_EN only).
- `ertn_cnt` output 32: number of ERTNs committed (EXCP_STAT_EN only).

## Operation
- States:
  - IDLE: accepts commits.
  - REDIR: a redirect is pending.
- Commit event (only in IDLE, with ws_valid=1):
  - exc = |ws_excp.
  - ertn = ws_ertn & ~exc. If an exception and ERTN occur together, the exception wins and the ERTN is dropped.
- Priority when several flags are set: INT > ADEF > INE > SYS > BRK > ALE. wb_ecode takes the code of the highest-priority set flag.
- On exc:
  - wb_ex=1, wb_pc=ws_pc, flush=1.
  - redirect_pc register <= ex_entry.
  - Go to REDIR.
- On ertn:
  - ertn_flush=1, flush=1.
  - redirect_pc register <= era_value.
  - Go to REDIR.
- ws_valid=1 with no exception and no ERTN: normal retire; all commit outputs stay 0 and the state stays IDLE.
- REDIR:
  - redirect_valid=1; redirect_pc held stable.
  - ws_allowin=0; all commit outputs are forced to 0 whatever ws_valid/ws_excp are.
  - Go to IDLE on the cycle redirect_valid & redirect_ready are both 1.
- ws_allowin = (state==IDLE).
- wb_pc and wb_ecode are 0 whenever wb_ex=0.

## Timing
- wb_ex, ertn_flush, wb_ecode, wb_pc and flush are combinational from the WB inputs during the commit cycle C. Each is a single-cycle pulse. The CSR unit samples them at the end of C.
- ex_entry and era_value are sampled in cycle C, before the CSR update takes effect.
- redirect_valid rises in C+1. The earliest handshake is in C+1, which gives IDLE in C+2.
- redirect_valid must not drop, and redirect_pc must not change, until the handshake completes.
- Reset, including reset during REDIR:
  - state=IDLE, redirect_valid=0, redirect_pc=0.
  - All pulse outputs 0, ws_allowin=1, counters 0.
  - The pending redirect is discarded.
- The counters increment in the cycle after C and wrap from 0xFFFFFFFF to 0.

## Configuration
- `EXCP_STAT_EN` defined:
  - excp_cnt and ertn_cnt exist and count committed exceptions and ERTNs (not dropped ones).
- `EXCP_STAT_EN` undefined:
  - Both counter ports and their registers are absent.
  - All other behaviour is identical.

## Test plan
- Exception: ws_valid=1, ws_excp=6'b001000 (SYS), ws_pc=0x1C000100, ex_entry=0x1C008000 -> in C, wb_ex=1, wb_ecode=0x0B, wb_pc=0x1C000100, flush=1. In C+1, redirect_valid=1, redirect_pc=0x1C008000.
- Priority: ws_excp=6'b100011 (INT+ADEF+ALE) -> wb_ecode=0x00. Then ws_excp=6'b100110 -> wb_ecode=0x08.
- ERTN: ws_ertn=1 with era_value=0x1C000204 -> ertn_flush=1, wb_ex=0, redirect_pc=0x1C000204. With ws_excp=6'b000100 (INE) on the same instruction -> wb_ex=1, wb_ecode=0x0D, ertn_flush=0.
- Backpressure: hold redirect_ready=0 for 5 cycles while driving new exceptions -> redirect_valid and redirect_pc are stable, ws_allowin=0, no wb_ex pulses. Then redirect_ready=1 -> IDLE next cycle and ws_allowin=1.
- Reset mid-REDIR: pull resetn=0 during REDIR -> next cycle redirect_valid=0, ws_allowin=1, counters 0.
- With EXCP_STAT_EN: 3 exceptions and 2 ERTNs -> excp_cnt=3, ertn_cnt=2. Preloading excp_cnt to 0xFFFFFFFF and committing one exception wraps it to 0.
